// File: rtl/sine_pkg.sv
// Shared widths and types for the sine NCO slice; the defaults match the sine_table
// lookup it drives.
package sine_pkg;

  localparam int SINE_PHASE_WIDTH   = 32;
  localparam int SINE_ID_WIDTH      = 12;
  localparam int SINE_DATA_WIDTH    = 32;
  localparam int SINE_TABLE_LATENCY = 2;
  localparam int SINE_FIFO_DEPTH    = 8;

  typedef logic [SINE_PHASE_WIDTH-1:0] phase_t;

endpackage

// File: rtl/sine_nco_if.sv
// Table lookup bus plus the downstream sample stream. The NCO is the master, and the
// table and consumer side is the slave.
interface sine_nco_if
  import sine_pkg::*;
#(
  parameter int ID_WIDTH   = SINE_ID_WIDTH,
  parameter int DATA_WIDTH = SINE_DATA_WIDTH
);

  logic [ID_WIDTH-1:0]   id_out;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] sample_out;
  logic                  sample_valid_out;
  logic                  sample_ready_in;

  modport master (
    output id_out,
    output sample_out,
    output sample_valid_out,
    input  data_in,
    input  sample_ready_in
  );

  modport slave (
    input  id_out,
    input  sample_out,
    input  sample_valid_out,
    output data_in,
    output sample_ready_in
  );

endinterface

// File: rtl/sine_nco_sample_fifo.sv
// First-word-fall-through FIFO with a registered head. The head register keeps the last
// popped word while the FIFO is empty.
module sample_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // The head is reloaded from the next stored entry, or from the word arriving this
  // cycle when the FIFO would otherwise be empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      data   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      if (do_pop) begin
        if (count > CNT_W'(1)) data <= mem[rd_ptr + 1'b1];
        else if (do_push)      data <= push_data;
      end else if (empty && do_push) begin
        data <= push_data;
      end
    end
  end

endmodule

// File: rtl/sine_nco.sv
// Phase-accumulator NCO. It requests sine table indices, tracks the table's fixed read
// latency, and buffers the returned samples for a valid/ready consumer.
module sine_nco
  import sine_pkg::*;
#(
  parameter int PHASE_WIDTH   = SINE_PHASE_WIDTH,
  parameter int ID_WIDTH      = SINE_ID_WIDTH,
  parameter int DATA_WIDTH    = SINE_DATA_WIDTH,
  parameter int TABLE_LATENCY = SINE_TABLE_LATENCY,
  parameter int FIFO_DEPTH    = SINE_FIFO_DEPTH
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   enable_in,
  input  logic                   sync_in,
  input  logic [PHASE_WIDTH-1:0] phase_inc_in,
  input  logic [PHASE_WIDTH-1:0] phase_offset_in,
  output logic                   stall_out,
  sine_nco_if.master             bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [PHASE_WIDTH-1:0] acc_q;
  logic [PHASE_WIDTH-1:0] base;
  logic [ID_WIDTH-1:0]    next_id;
  logic [TABLE_LATENCY:0] tag_q;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   issue;
  logic                   push;
  logic                   pop;
  int                     in_flight;

  always_comb begin
    in_flight = 0;
    for (int i = 0; i <= TABLE_LATENCY; i++) in_flight += int'(tag_q[i]);
  end

  // In-flight requests reserve FIFO slots, so a returning sample always finds space.
  assign issue     = enable_in && !fifo_full && ((in_flight + int'(fifo_count)) < FIFO_DEPTH);
  assign stall_out = enable_in && !issue;
  assign base      = sync_in ? '0 : acc_q;
  assign next_id   = ID_WIDTH'((base + phase_offset_in) >> (PHASE_WIDTH - ID_WIDTH));
  assign push      = tag_q[TABLE_LATENCY];
  assign pop       = bus.sample_valid_out && bus.sample_ready_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      acc_q      <= '0;
      tag_q      <= '0;
      bus.id_out <= '0;
    end else begin
      tag_q <= {tag_q[TABLE_LATENCY-1:0], issue};
      if (issue) begin
        bus.id_out <= next_id;
        acc_q      <= base + phase_inc_in;
      end else begin
        acc_q      <= base;
      end
    end
  end

  sample_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .push      (push),
    .push_data (bus.data_in),
    .pop       (pop),
    .data      (bus.sample_out),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.sample_valid_out = !fifo_empty;

endmodule

// File: tb/tb_sine_nco.sv
// Scoreboard bench for sine_nco. Each expected issue queues the table sample for its id,
// and a separate monitor checks every delivered sample in order.
module tb_sine_nco;
  import sine_pkg::*;

  logic   clk_in;
  logic   rst_in;
  logic   enable_in;
  logic   sync_in;
  phase_t phase_inc_in;
  phase_t phase_offset_in;
  logic   stall_out;

  logic [31:0] d1;
  logic [31:0] d2;
  logic [31:0] exp_q [$];
  int          vectors     = 0;
  int          miscompares = 0;

  sine_nco_if bus ();

  sine_nco dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .enable_in       (enable_in),
    .sync_in         (sync_in),
    .phase_inc_in    (phase_inc_in),
    .phase_offset_in (phase_offset_in),
    .stall_out       (stall_out),
    .bus             (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] model(input logic [11:0] id);
    return {id, ~id, 8'h5A};
  endfunction

  // Table stand-in with a two-cycle read latency.
  always @(posedge clk_in) begin
    d1 <= model(bus.id_out);
    d2 <= d1;
  end
  assign bus.data_in = d2;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyReset();
    rst_in    = 1'b0;
    enable_in = 1'b0;
    sync_in   = 1'b0;
    exp_q.delete();
    repeat (2) step();
    rst_in = 1'b1;
    step();
  endtask

  // Runs one cycle with the given controls. When an issue is expected, it queues the
  // sample and checks the registered index.
  task automatic applyStimulus(input bit en, input bit sy, input bit expect_issue,
                               input logic [11:0] exp_id, input string name);
    enable_in = en;
    sync_in   = sy;
    @(negedge clk_in);
    checkOutput({name, "_stall"}, 32'(stall_out), 32'(en && !expect_issue));
    if (expect_issue) exp_q.push_back(model(exp_id));
    step();
    sync_in = 1'b0;
    if (expect_issue) checkOutput({name, "_id"}, 32'(bus.id_out), 32'(exp_id));
  endtask

  task automatic drain(input string name);
    int n = 0;
    enable_in = 1'b0;
    bus.sample_ready_in = 1'b1;
    while ((exp_q.size() != 0) && (n < 60)) begin
      step();
      n++;
    end
    step();
    checkOutput({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    checkOutput({name, "_drain_valid"}, 32'(bus.sample_valid_out), 32'd0);
  endtask

  always @(negedge clk_in) begin
    if (rst_in && bus.sample_valid_out && bus.sample_ready_in) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_sample: got %0h, wanted none", bus.sample_out);
      end else begin
        checkOutput("sample", bus.sample_out, exp_q.pop_front());
      end
    end
    if (rst_in && dut.u_fifo.push && dut.u_fifo.full) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL overflow: got push into full FIFO, wanted none");
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.sample_ready_in = 1'b1;
    phase_inc_in        = 32'h0010_0000;
    phase_offset_in     = '0;
    enable_in           = 1'b0;
    sync_in             = 1'b0;
    rst_in              = 1'b0;
    #3;
    checkOutput("reset_id", 32'(bus.id_out), 32'd0);
    checkOutput("reset_valid", 32'(bus.sample_valid_out), 32'd0);
    checkOutput("reset_sample", bus.sample_out, 32'd0);
    checkOutput("reset_stall", 32'(stall_out), 32'd0);

    $display("[TB] linear ramp, inc 2^20");
    applyReset();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 12'(k), "ramp");
      if (k < 7) checkOutput("ramp_first_valid", 32'(bus.sample_valid_out), 32'(k >= 3));
    end
    drain("ramp");

    $display("[TB] quarter steps, inc 2^30");
    applyReset();
    phase_inc_in = 32'h4000_0000;
    applyStimulus(1'b1, 1'b0, 1'b1, 12'd0,    "quarter");
    applyStimulus(1'b1, 1'b0, 1'b1, 12'd1024, "quarter");
    applyStimulus(1'b1, 1'b0, 1'b1, 12'd2048, "quarter");
    applyStimulus(1'b1, 1'b0, 1'b1, 12'd3072, "quarter");
    applyStimulus(1'b1, 1'b0, 1'b1, 12'd0,    "quarter_wrap");
    drain("quarter");

    $display("[TB] backpressure");
    applyReset();
    phase_inc_in        = 32'h0010_0000;
    bus.sample_ready_in = 1'b0;
    for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b0, k < 8, 12'(k), "bp");
    checkOutput("bp_hold_id", 32'(bus.id_out), 32'd7);
    checkOutput("bp_valid", 32'(bus.sample_valid_out), 32'd1);
    bus.sample_ready_in = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 12'd0, "bp_release");
    for (int j = 0; j < 5; j++) applyStimulus(1'b1, 1'b0, 1'b1, 12'(8 + j), "bp_resume");
    drain("bp");

    $display("[TB] sync restart");
    applyReset();
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b0, 1'b1, 12'(k), "sync_pre");
    applyStimulus(1'b1, 1'b1, 1'b1, 12'd0, "sync_hit");
    applyStimulus(1'b1, 1'b0, 1'b1, 12'd1, "sync_next");
    drain("sync");

    $display("[TB] zero increment, offset 2^31");
    applyReset();
    phase_inc_in    = '0;
    phase_offset_in = 32'h8000_0000;
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b0, 1'b1, 12'd2048, "const");
    drain("const");

    $display("[TB] reset mid-stream");
    applyReset();
    phase_inc_in        = 32'h0010_0000;
    phase_offset_in     = 32'h8000_0000;
    bus.sample_ready_in = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b1, 12'(2048 + k), "pre_rst");
    enable_in = 1'b0;
    repeat (6) step();
    checkOutput("pre_rst_valid", 32'(bus.sample_valid_out), 32'd1);
    #2;
    rst_in = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("async_valid_drop", 32'(bus.sample_valid_out), 32'd0);
    checkOutput("async_id_clear", 32'(bus.id_out), 32'd0);
    step();
    step();
    phase_offset_in     = '0;
    bus.sample_ready_in = 1'b1;
    rst_in              = 1'b1;
    step();
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 1'b1, 12'(k), "post_rst");
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
